// File: rtl/divider_pkg.sv
// Shared definitions for the EX-stage radix-2 restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUNNING,
    DIV_DONE
  } div_state_t;

  localparam int DIV_STEPS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_STEPS);

  typedef logic [DIV_CNT_W-1:0] div_count_t;

  // stage_ex function codes that route to the divider.
  localparam logic [5:0] OP_DIV  = 6'h1A;
  localparam logic [5:0] OP_DIVU = 6'h1B;

  function automatic logic op_is_signed(input logic [5:0] funct);
    return funct == OP_DIV;
  endfunction

endpackage

// File: rtl/divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, sign fix-up on entry to DONE.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             busy
);

  localparam div_count_t LAST_STEP = div_count_t'(DIV_STEPS - 1);

  div_state_t        state;
  div_state_t        state_next;
  div_count_t        counter;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]  div_reg;
  logic [WIDTH:0]    trial;
  logic              neg_q;
  logic              neg_r;
  logic [WIDTH-1:0]  dividend_abs;
  logic [WIDTH-1:0]  divisor_abs;
  logic [WIDTH-1:0]  q_raw;
  logic [WIDTH-1:0]  r_raw;
  logic [WIDTH-1:0]  q_fix;
  logic [WIDTH-1:0]  r_fix;
  logic              accept;

  // The most negative value negates to itself, which is exactly right once treated as unsigned.
  always_comb begin
    dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    accept       = (state == DIV_IDLE) && start && !cancel;
  end

  always_comb begin
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, div_reg};
    if (!trial[WIDTH]) begin
      acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end
    q_raw = acc_step[WIDTH-1:0];
    r_raw = acc_step[2*WIDTH-1:WIDTH];
    q_fix = neg_q ? -q_raw : q_raw;
    r_fix = neg_r ? -r_raw : r_raw;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: begin
        if (accept) begin
          state_next = (divisor == '0) ? DIV_DONE : DIV_RUNNING;
        end
      end
      DIV_RUNNING: begin
        if (cancel) begin
          state_next = DIV_IDLE;
        end else if (counter == LAST_STEP) begin
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != DIV_IDLE);
    ready = (state == DIV_DONE) && !cancel;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= DIV_IDLE;
      counter   <= '0;
      acc       <= '0;
      div_reg   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_next;
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            counter <= '0;
            acc     <= {{WIDTH{1'b0}}, dividend_abs};
            div_reg <= divisor_abs;
            neg_q   <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= is_signed && dividend[WIDTH-1];
            if (divisor == '0) begin
              quotient  <= '0;
              remainder <= '0;
            end
          end
        end
        DIV_RUNNING: begin
          if (!cancel) begin
            acc     <= acc_step;
            counter <= counter + div_count_t'(1);
            if (counter == LAST_STEP) begin
              quotient  <= q_fix;
              remainder <= r_fix;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the divider: a native-arithmetic model predicts results and latency.
module tb_divider;
  import divider_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ready;
  logic        busy;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  divider #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .cancel    (cancel),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic exp_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sbv;
    e.lat = (b == 32'd0) ? 1 : 33;
    if (b == 32'd0) begin
      e.q = 32'd0;
      e.r = 32'd0;
    end else if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        sa  = a;
        sbv = b;
        e.q = sa / sbv;
        e.r = sa % sbv;
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
  task automatic applyStimulus(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   cycles;
    bit   seen;
    sb.push_back(model(sg, a, b));
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    cycles    = 0;
    seen      = 0;
    while (!seen && cycles < 100) begin
      @(negedge clock);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      cycles++;
      if (ready) seen = 1;
    end
    checkOutput({tag, " ready_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({tag, " latency"}, 32'(cycles), 32'(e.lat));
        checkOutput({tag, " quotient"}, quotient, e.q);
        checkOutput({tag, " remainder"}, remainder, e.r);
        checkOutput({tag, " busy_at_ready"}, 32'(busy), 32'd1);
      end
    end
    @(negedge clock);
    checkOutput({tag, " idle_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " idle_ready"}, 32'(ready), 32'd0);
  endtask

  initial begin
    logic [31:0] prev_q;
    logic [31:0] prev_r;
    bit          seen;
    int          n;

    $display("[TB] divider bench starting");
    repeat (2) @(negedge clock);
    checkOutput("reset quotient", quotient, 32'd0);
    checkOutput("reset remainder", remainder, 32'd0);
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    applyStimulus("T1 100/7", 1'b0, 32'd100, 32'd7);
    applyStimulus("T2 -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7);
    applyStimulus("T2 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9);
    applyStimulus("T3 5/0 u", 1'b0, 32'd5, 32'd0);
    applyStimulus("T3 5/0 s", 1'b1, 32'd5, 32'd0);

    // T4: cancel mid-run, results must hold their previous values.
    prev_q    = quotient;
    prev_r    = remainder;
    is_signed = 1'b0;
    dividend  = 32'hFFFF_FFFF;
    divisor   = 32'd3;
    start     = 1'b1;
    seen      = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (ready) seen = 1;
    end
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    if (ready) seen = 1;
    checkOutput("T4 cancel busy", 32'(busy), 32'd0);
    checkOutput("T4 cancel no_ready", 32'(seen), 32'd0);
    checkOutput("T4 cancel quotient_held", quotient, prev_q);
    checkOutput("T4 cancel remainder_held", remainder, prev_r);
    @(negedge clock);
    applyStimulus("T4 restart", 1'b0, 32'hFFFF_FFFF, 32'd3);

    // Cancel in IDLE blocks a simultaneous start.
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    cancel   = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    cancel = 1'b0;
    checkOutput("idle cancel busy", 32'(busy), 32'd0);

    // Cancel during DONE suppresses the ready pulse.
    is_signed = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd4;
    start     = 1'b1;
    seen      = 0;
    n         = 0;
    while (!seen && n < 100) begin
      @(negedge clock);
      start = 1'b0;
      n++;
      if (busy && n == 33) seen = 1;
    end
    cancel = 1'b1;
    #1;
    checkOutput("done cancel ready", 32'(ready), 32'd0);
    checkOutput("done cancel busy", 32'(busy), 32'd1);
    @(negedge clock);
    cancel = 1'b0;
    checkOutput("done cancel idle", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      if (i == 3) b = 32'd0;
      else if (i % 2 == 0) b = $urandom;
      else b = 32'($urandom_range(1, 20)) ^ (sg ? 32'hFFFF_FFFF : 32'd0);
      applyStimulus($sformatf("rand%0d", i), sg, a, b);
    end

    applyStimulus("T5 overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus("T5 back2back", 1'b0, 32'd7, 32'd2);

    // T6: synchronous reset mid-run with start held high.
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    start     = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b0;
    start = 1'b1;
    @(negedge clock);
    checkOutput("T6 busy", 32'(busy), 32'd0);
    checkOutput("T6 ready", 32'(ready), 32'd0);
    checkOutput("T6 quotient", quotient, 32'd0);
    checkOutput("T6 remainder", remainder, 32'd0);
    @(negedge clock);
    checkOutput("T6 start_ignored", 32'(busy), 32'd0);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    checkOutput("T6 after_release", 32'(busy), 32'd0);

    checkOutput("sb drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
